pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel 50 MHz-based PWM block in the motor speed path. All channels share one period counter and one period value, and each channel has its own duty value and output enable. Configuration is double-buffered: written into shadow registers and applied glitch-free at the next period boundary. It supports edge-aligned and center-aligned counting, and emits a period-start strobe for ADC/sampling synchronisation.

---
 rtl/pwm_multi_ch.sv | 191 +++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator with one shared period counter, per-channel
// duty compare and double-buffered configuration (shadow -> active at period boundaries).
// Build option: define PWM_CENTER_ALIGN_EN to add center-aligned (up/down) counting;
// without it the block is edge-aligned only and align_center is ignored.
module pwm_multi_ch #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_en,
    input  logic [CNT_W-1:0]    period,
    input  logic [CH*CNT_W-1:0] duty,
    input  logic                align_center,
    input  logic                cfg_load,
    input  logic [CH-1:0]       ch_out_en,
    output logic [CH-1:0]       pwm_out,
    output logic                period_start,
    output logic                load_ack
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    logic [CNT_W-1:0]         s_period_q;
    logic [CNT_W-1:0]         a_period_q;
    logic [CH-1:0][CNT_W-1:0] s_duty_q;
    logic [CH-1:0][CNT_W-1:0] a_duty_q;
    logic                     load_pending_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [CNT_W-1:0]         period_m1;
    logic                     period_zero;
    logic                     boundary;
    logic                     first_cnt;
    logic                     xfer;
    logic                     run;
    logic [CH-1:0]            pwm_d;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {StUp, StDown} dir_e;
    dir_e dir_q;
    dir_e dir_d;
    logic s_center_q;
    logic a_center_q;
`else
    logic unused_align_center;
    assign unused_align_center = align_center;
`endif

    // Terminal count of the active period; only meaningful when the period is non-zero
    always_comb begin
        period_zero = (a_period_q == '0);
        period_m1   = period_zero ? '0 : a_period_q - One;
    end

    // Counter next state, boundary detection and first-count-of-period detection
    always_comb begin
        cnt_d     = '0;
        boundary  = 1'b0;
        first_cnt = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d     = StUp;
`endif
        if (period_zero) begin
            // No period in progress, so a pending load may apply on any cycle
            boundary = 1'b1;
        end else begin
`ifdef PWM_CENTER_ALIGN_EN
            if (a_center_q) begin
                first_cnt = (dir_q == StUp) && (cnt_q == '0);
                if (dir_q == StUp) begin
                    if (cnt_q >= period_m1) begin
                        // Hold the peak for one extra clock, then count down
                        cnt_d = period_m1;
                        dir_d = StDown;
                    end else begin
                        cnt_d = cnt_q + One;
                        dir_d = StUp;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        boundary = 1'b1;
                        cnt_d    = '0;
                        dir_d    = StUp;
                    end else begin
                        cnt_d = cnt_q - One;
                        dir_d = StDown;
                    end
                end
            end else begin
                first_cnt = (cnt_q == '0);
                boundary  = (cnt_q >= period_m1);
                cnt_d     = boundary ? '0 : cnt_q + One;
            end
`else
            first_cnt = (cnt_q == '0);
            boundary  = (cnt_q >= period_m1);
            cnt_d     = boundary ? '0 : cnt_q + One;
`endif
        end
        if (!pwm_en) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = StUp;
`endif
        end
    end

    // A pending load is applied at a boundary, or at once while the counter is stopped
    assign xfer = load_pending_q && (!pwm_en || boundary);
    assign run  = pwm_en && !period_zero;

    // Per-channel duty compare, gated by run state and output enable
    always_comb begin
        pwm_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            pwm_d[i] = run && ch_out_en[i] && (cnt_q < a_duty_q[i]);
        end
    end

    // Shadow registers and load-pending flag; a new write keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            s_period_q     <= '0;
            s_duty_q       <= '0;
            load_pending_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            s_center_q     <= 1'b0;
`endif
        end else begin
            if (cfg_load) begin
                s_period_q <= period;
                s_duty_q   <= duty;
`ifdef PWM_CENTER_ALIGN_EN
                s_center_q <= align_center;
`endif
            end
            if (cfg_load) begin
                load_pending_q <= 1'b1;
            end else if (xfer) begin
                load_pending_q <= 1'b0;
            end
        end
    end

    // Active registers, copied from the shadow set on transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            a_period_q <= '0;
            a_duty_q   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            a_center_q <= 1'b0;
`endif
        end else if (xfer) begin
            a_period_q <= s_period_q;
            a_duty_q   <= s_duty_q;
`ifdef PWM_CENTER_ALIGN_EN
            a_center_q <= s_center_q;
`endif
        end
    end

    // Shared period counter and count direction
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q <= StUp;
`endif
        end else begin
            cnt_q <= cnt_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q <= dir_d;
`endif
        end
    end

    // Registered outputs: one cycle behind the count that produced them
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            pwm_out      <= pwm_d;
            period_start <= run && first_cnt;
            load_ack     <= xfer;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: self-checking bench for pwm_multi_ch (CH=4, CNT_W=32).
// Expected {load_ack, period_start, pwm_out} words are queued as stimulus is driven and
// popped when the corresponding registered output appears.
module tb_pwm_multi_ch;

`ifdef PWM_CENTER_ALIGN_EN
    localparam bit Center = 1'b1;
`else
    localparam bit Center = 1'b0;
`endif

    localparam logic [127:0] DBase = {32'd12, 32'd10, 32'd3, 32'd0};
    localparam logic [127:0] DOne  = {32'd12, 32'd10, 32'd3, 32'd1};
    localparam logic [127:0] DNew  = {32'd12, 32'd10, 32'd3, 32'd7};
    localparam logic [127:0] DMid  = {32'd12, 32'd10, 32'd3, 32'd5};
    localparam logic [127:0] DCtr  = {32'd2, 32'd2, 32'd2, 32'd2};

    logic         clk = 1'b0;
    logic         rst;
    logic         pwm_en;
    logic [31:0]  period;
    logic [127:0] duty;
    logic         align_center;
    logic         cfg_load;
    logic [3:0]   ch_out_en;
    logic [3:0]   pwm_out;
    logic         period_start;
    logic         load_ack;

    int           total = 0;
    int           bad = 0;
    logic [5:0]   exp_q[$];

    pwm_multi_ch #(
        .CH    (4),
        .CNT_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_en       (pwm_en),
        .period       (period),
        .duty         (duty),
        .align_center (align_center),
        .cfg_load     (cfg_load),
        .ch_out_en    (ch_out_en),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .load_ack     (load_ack)
    );

    always #5 clk = ~clk;

    // Channel compare: high while count < duty
    function automatic logic [3:0] cmp_bits(input int c, input logic [127:0] d);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (32'(c) < d[i*32 +: 32]);
        return b;
    endfunction

    // Expected {period_start, pwm} for step s of a P=5, D=2 run in the build's mode
    function automatic logic [4:0] ctr_word(input int s);
        int ph;
        int c;
        if (Center) begin
            ph = s % 10;
            c  = (ph < 5) ? ph : 9 - ph;
            return {ph == 0, cmp_bits(c, DCtr)};
        end
        c = s % 5;
        return {c == 0, cmp_bits(c, DCtr)};
    endfunction

    task automatic test_reset();
        logic [5:0] got;
        logic [5:0] want;
        rst = 1'b1; pwm_en = 1'b1; cfg_load = 1'b1; period = 32'd3; duty = DCtr;
        align_center = 1'b0; ch_out_en = 4'hF;
        for (int s = 0; s < 5; s++) begin
            exp_q.push_back(6'b0);
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL reset s=%0d got=%b want=%b", s, got, want);
            end
            if (s == 2) begin
                rst = 1'b0; cfg_load = 1'b0; pwm_en = 1'b0;
            end
        end
    endtask

    task automatic test_edge();
        logic [5:0] got;
        logic [5:0] want;
        int c;
        period = 32'd10; duty = DBase; align_center = 1'b0; cfg_load = 1'b1;
        exp_q.push_back(6'b000000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL edge_load got=%b want=%b", got, want); end
        cfg_load = 1'b0;
        exp_q.push_back(6'b100000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL edge_ack got=%b want=%b", got, want); end
        pwm_en = 1'b1;
        for (int s = 0; s < 30; s++) begin
            c = s % 10;
            exp_q.push_back({1'b0, c == 0, cmp_bits(c, DBase)});
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL edge s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_double_buffer();
        logic [5:0] got;
        logic [5:0] want;
        int c;
        for (int s = 0; s < 20; s++) begin
            cfg_load = (s == 2) || (s == 4);
            duty     = (s < 3) ? DOne : DNew;
            c = s % 10;
            exp_q.push_back({s == 9, c == 0, cmp_bits(c, (s < 10) ? DBase : DNew)});
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL dbuf s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_cfg_on_boundary();
        logic [5:0] got;
        logic [5:0] want;
        int c;
        logic [127:0] d;
        for (int s = 0; s < 36; s++) begin
            cfg_load = (s == 3) || (s == 9);
            period   = (s < 9) ? 32'd10 : 32'd8;
            duty     = (s < 9) ? DMid : DNew;
            if (s < 20) begin
                c = s % 10; d = (s < 10) ? DNew : DMid;
            end else begin
                c = (s - 20) % 8; d = DNew;
            end
            exp_q.push_back({(s == 9) || (s == 19), c == 0, cmp_bits(c, d)});
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL bnd s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_center();
        logic [5:0] got;
        logic [5:0] want;
        pwm_en = 1'b0; cfg_load = 1'b1; period = 32'd5; duty = DCtr; align_center = 1'b1;
        exp_q.push_back(6'b000000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL ctr_load got=%b want=%b", got, want); end
        cfg_load = 1'b0;
        exp_q.push_back(6'b100000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL ctr_ack got=%b want=%b", got, want); end
        pwm_en = 1'b1;
        for (int s = 0; s < 20; s++) begin
            exp_q.push_back({1'b0, ctr_word(s)});
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL center s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_out_enable();
        logic [5:0] got;
        logic [5:0] want;
        ch_out_en = 4'b1101;
        for (int s = 0; s < 10; s++) begin
            exp_q.push_back({1'b0, ctr_word(s) & 5'b11101});
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL out_en s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_zero_period();
        logic [5:0] got;
        logic [5:0] want;
        int b;
        b = Center ? 9 : 4;
        ch_out_en = 4'hF; period = 32'd0; duty = DCtr;
        for (int s = 0; s < 20; s++) begin
            cfg_load = (s == 0);
            exp_q.push_back((s <= b) ? {s == b, ctr_word(s)} : 6'b000000);
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL p0 s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        logic [5:0] want;
        int c;
        pwm_en = 1'b0; cfg_load = 1'b1; period = 32'd10; duty = DBase; align_center = 1'b0;
        exp_q.push_back(6'b000000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_load got=%b want=%b", got, want); end
        cfg_load = 1'b0;
        exp_q.push_back(6'b100000);
        @(negedge clk);
        got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL rst_ack got=%b want=%b", got, want); end
        for (int s = 0; s < 30; s++) begin
            pwm_en   = !((s == 12) || (s == 13));
            cfg_load = (s == 3) || (s == 12);
            period   = (s == 3) ? 32'd4 : 32'd10;
            rst      = (s == 6);
            if (s < 6) begin
                c = s % 10;
                exp_q.push_back({1'b0, c == 0, cmp_bits(c, DBase)});
            end else if (s < 14) begin
                exp_q.push_back((s == 13) ? 6'b100000 : 6'b000000);
            end else begin
                c = (s - 14) % 10;
                exp_q.push_back({1'b0, c == 0, cmp_bits(c, DBase)});
            end
            @(negedge clk);
            got = {load_ack, period_start, pwm_out}; want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL rst_mid s=%0d got=%b want=%b", s, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_double_buffer();
        test_cfg_on_boundary();
        test_center();
        test_out_enable();
        test_zero_period();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
